// File: rtl/pe_array_ctrl.sv
// rtl/pe_array_ctrl.sv - Kernel-load, row-stream and drain sequencer for the 3x3 PE array
module pe_array_ctrl #(
   parameter int INPUTS_MAC    = 6,
   parameter int COLS_MAC      = 4,
   parameter int ARRAY_LATENCY = 3,
   parameter int ROW_W         = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ROW_W-1:0]  num_rows,
   input  logic [7:0]        kernel_in [0:8],
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              rd_en,
   output logic [ROW_W-1:0]  rd_addr,
   input  logic [7:0]        rd_data [0:INPUTS_MAC-1],
   output logic              write_kernel,
   output logic [7:0]        weights [0:8],
   output logic [7:0]        inputs_mac [0:INPUTS_MAC-1],
   output logic              out_valid,
   output logic [ROW_W-1:0]  out_row
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_K,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);
   localparam logic [ROW_W-1:0] ROW_TWO   = ROW_W'(2);
   localparam logic [ROW_W-1:0] ROW_THREE = ROW_W'(3);

   // The array produces INPUTS_MAC-2 window columns; any other pairing is a build error.
   generate
      if (COLS_MAC != INPUTS_MAC - 2) begin : g_cols_check
         $error("pe_array_ctrl: COLS_MAC must equal INPUTS_MAC-2");
      end
   endgenerate

   state_t             r_state;
   logic [ROW_W-1:0]   r_num_rows;
   logic               r_rd_en_d;
   logic [ROW_W-1:0]   r_rd_addr_d;
   logic               r_tag_v   [0:ARRAY_LATENCY-1];
   logic [ROW_W-1:0]   r_tag_idx [0:ARRAY_LATENCY-1];

   logic               w_tag_in_v;
   logic [ROW_W-1:0]   w_tag_in_idx;
   logic               w_last_out;

   // A row that lands on inputs_mac completes a 3-row window once it is the third row or later.
   assign w_tag_in_v   = r_rd_en_d && (r_rd_addr_d >= ROW_TWO);
   assign w_tag_in_idx = r_rd_addr_d - ROW_TWO;
   assign w_last_out   = out_valid && (out_row == (r_num_rows - ROW_THREE));

   // Run sequencer: start handshake, kernel load strobe and row-buffer read addressing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_num_rows   <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         rd_en        <= 1'b0;
         rd_addr      <= '0;
         write_kernel <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            weights[i] <= 8'd0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_num_rows <= num_rows;
                  for (int i = 0; i < 9; i++) begin
                     weights[i] <= kernel_in[i];
                  end
                  if (num_rows < ROW_THREE) begin
                     // Fewer rows than the kernel height: nothing to compute, report at once.
                     err     <= 1'b1;
                     done    <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     err          <= 1'b0;
                     busy         <= 1'b1;
                     write_kernel <= 1'b1;
                     r_state      <= S_LOAD_K;
                  end
               end
            end
            S_LOAD_K: begin
               write_kernel <= 1'b0;
               rd_en        <= 1'b1;
               rd_addr      <= '0;
               r_state      <= S_STREAM;
            end
            S_STREAM: begin
               if (rd_addr == (r_num_rows - ROW_ONE)) begin
                  rd_en   <= 1'b0;
                  r_state <= S_DRAIN;
               end else begin
                  rd_addr <= rd_addr + ROW_ONE;
               end
            end
            S_DRAIN: begin
               // Finish once the last output row has been flagged to the array consumer.
               if (w_last_out) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Data path: register read data (or zero rows) into the array and track window results.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_en_d   <= 1'b0;
         r_rd_addr_d <= '0;
         out_valid   <= 1'b0;
         out_row     <= '0;
         for (int p = 0; p < INPUTS_MAC; p++) begin
            inputs_mac[p] <= 8'd0;
         end
         for (int i = 0; i < ARRAY_LATENCY; i++) begin
            r_tag_v[i]   <= 1'b0;
            r_tag_idx[i] <= '0;
         end
      end else begin
         r_rd_en_d   <= rd_en;
         r_rd_addr_d <= rd_addr;
         for (int p = 0; p < INPUTS_MAC; p++) begin
            inputs_mac[p] <= r_rd_en_d ? rd_data[p] : 8'd0;
         end
         r_tag_v[0]   <= w_tag_in_v;
         r_tag_idx[0] <= w_tag_in_v ? w_tag_in_idx : '0;
         for (int i = 1; i < ARRAY_LATENCY; i++) begin
            r_tag_v[i]   <= r_tag_v[i-1];
            r_tag_idx[i] <= r_tag_idx[i-1];
         end
         out_valid <= r_tag_v[ARRAY_LATENCY-1];
         out_row   <= r_tag_v[ARRAY_LATENCY-1] ? r_tag_idx[ARRAY_LATENCY-1] : '0;
      end
   end

endmodule
